// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_initiator: load/store initiator driving the data-memory strobe/stall |
// | handshake; optional stall-wait timeout under macro LSU_TIMEOUT_EN.           |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module lsu_mem_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic        mem_clk_stall,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_we;
    logic [3:0] w_mask;
    logic       w_legal;
    logic       w_misal;
    logic       w_accept;

`ifdef LSU_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [C_CNT_W-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // Gating on stall keeps a responder orphaned by reset from seeing a new strobe.
    assign req_ready = (r_state == S_IDLE) && !mem_clk_stall;
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_mask  = 4'b0000;
        w_legal = 1'b0;
        w_misal = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                w_mask[2:0] = 3'b001;
                w_legal     = 1'b1;
            end
            2'b01: begin
                w_mask[2:0] = 3'b011;
                w_legal     = 1'b1;
                w_misal     = req_addr[0];
            end
            2'b10: begin
                w_mask[2:0] = 3'b111;
                w_legal     = !req_funct3[2];
                w_misal     = |req_addr[1:0];
            end
            default: ;
        endcase
        if (req_we && req_funct3[2]) begin
            w_legal = 1'b0;
        end
        w_mask[3] = !req_we && (req_funct3[2:1] == 2'b00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_sign_mask  <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            r_cnt          <= '0;
`endif
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        mem_addr       <= req_addr;
                        mem_write_data <= req_wdata;
                        mem_sign_mask  <= w_mask;
                        r_we           <= req_we;
                        if (!w_legal || w_misal) begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            r_state      <= S_ISSUE;
                            mem_memread  <= !req_we;
                            mem_memwrite <= req_we;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_HI;
`ifdef LSU_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if (r_state == S_WAIT_LO && !mem_clk_stall) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_we ? 32'd0 : mem_read_data;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_cnt == C_TO_LAST) begin
                        r_state   <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end
`endif
                    else begin
                        if (r_state == S_WAIT_HI && mem_clk_stall) begin
                            r_state <= S_WAIT_LO;
                        end
`ifdef LSU_TIMEOUT_EN
                        r_cnt <= r_cnt + C_CNT_W'(1);
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_mem_initiator: cycle-timeline model plus randomized responder.        |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_initiator;
    localparam int MAXC = 4096;
`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        mem_memread, mem_memwrite, mem_clk_stall;
    logic [3:0]  mem_sign_mask;

    lsu_mem_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_sign_mask(mem_sign_mask), .mem_clk_stall(mem_clk_stall),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Expected outputs per cycle; cycle n is the interval following clock edge n.
    typedef struct {
        bit          rd, wr, rv, err, busy, ok;
        logic [31:0] rdata, addr, wdata;
        logic [3:0]  mask;
    } exp_t;
    typedef struct {
        int          d;
        int          h;
        logic [31:0] rdata;
    } rsp_t;

    exp_t        tl [MAXC];
    rsp_t        rq [$];
    int          rd_q [$];
    int          edge_n = 0;
    int          free_edge = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic [31:0] model_rdata = 32'd0;
    bit [2:0]    load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, edge_n);
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    endtask

    function automatic bit is_bad(input bit we, input bit [2:0] f3, input logic [31:0] a);
        bit legal;
        int sz;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f3[1:0];
        return !legal || ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic logic [3:0] exp_mask(input bit we, input bit [2:0] f3);
        int sz;
        sz = 1 << f3[1:0];
        return {(!we && (f3 == 3'd0 || f3 == 3'd1)),
                (sz == 1) ? 3'b001 : (sz == 2) ? 3'b011 : 3'b111};
    endfunction

    // d: idle cycles before the responder raises stall (-1 = never); h: stall length.
    task automatic send(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int d, input int h, input bit keep, output int acc);
        int a, last;
        bit bad;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        a    = (edge_n + 1 > free_edge) ? edge_n + 1 : free_edge;
        bad  = is_bad(we, f3, addr);
        last = bad ? a : a + 2 + d + h;
        if (last + 4 >= MAXC) begin
            n_chk++; n_err++;
            $display("FAIL timeline_overflow: got %0d expected below %0d", last, MAXC);
            summary();
            $fatal(1, "timeline overflow");
        end
        for (int c = a; c <= last; c++) begin
            tl[c].busy = 1'b1; tl[c].ok = !bad; tl[c].addr = addr; tl[c].wdata = wdata;
            tl[c].mask = exp_mask(we, f3);
        end
        tl[last].rv    = 1'b1;
        tl[last].err   = bad;
        tl[last].rdata = (bad || we) ? 32'd0 : rdata;
        if (!bad) begin
            tl[a].rd = !we;
            tl[a].wr = we;
            rq.push_back('{d, h, rdata});
        end
        free_edge = bad ? a + 2 : a + 4 + d + h;
        acc = a;
        while (edge_n < a) begin @(posedge clk); #1; end
        if (!keep) begin
            req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom);
            req_funct3 = 3'($urandom);
        end
    endtask

    initial begin
        forever begin @(posedge clk); edge_n++; end
    end

    // Responder: strobe seen -> optional delay -> stall high for h cycles -> data.
    initial begin
        rsp_t r;
        mem_clk_stall = 1'b0;
        mem_read_data = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_memread || mem_memwrite) begin
                if (rq.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_strobe: got strobe expected none at cycle %0d", edge_n);
                end else begin
                    r = rq.pop_front();
                    if (r.d >= 0) begin
                        @(posedge clk);
                        repeat (r.d) @(posedge clk);
                        #1 mem_clk_stall = 1'b1; mem_read_data = $urandom;
                        repeat (r.h) @(posedge clk);
                        #1 mem_clk_stall = 1'b0; mem_read_data = r.rdata;
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_memread) rd_q.push_back(edge_n);
            if (chk_en && edge_n < MAXC) begin
                e = tl[edge_n];
                if (e.rv) model_rdata = e.rdata;
                chk("memread", mem_memread, e.rd);
                chk("memwrite", mem_memwrite, e.wr);
                chk("rsp_valid", rsp_valid, e.rv);
                chk("rsp_err", rsp_err, e.rv && e.err);
                chk("busy", busy, e.busy);
                chk("req_ready", req_ready, !e.busy && !mem_clk_stall);
                chk("rsp_rdata", rsp_rdata, model_rdata);
                if (e.busy) begin
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_write_data", mem_write_data, e.wdata);
                    if (e.ok) chk("mem_sign_mask", mem_sign_mask, e.mask);
                end
            end
        end
    end

    initial begin
        #500000;
        n_chk++; n_err++;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2;
        bit we, keep;
        bit [2:0] f3;
        logic [31:0] addr;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_memread", mem_memread, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;

        send(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b0, a);
        @(negedge clk);
        chk("lw_memread", mem_memread, 1'b1);
        chk("lw_mask", mem_sign_mask, 4'b0111);
        repeat (3) @(negedge clk);
        chk("lw_not_early", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lw_rsp_valid", rsp_valid, 1'b1);
        chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("lw_err", rsp_err, 1'b0);

        send(1'b1, 3'b000, 32'h103, 32'hA5, 32'h0, 1, 1, 1'b0, a);
        @(negedge clk);
        chk("sb_memwrite", mem_memwrite, 1'b1);
        chk("sb_mask", mem_sign_mask, 4'b0001);
        chk("sb_addr", mem_addr, 32'h103);
        chk("sb_wdata", mem_write_data, 32'hA5);
        repeat (4) @(negedge clk);
        chk("sb_rsp_valid", rsp_valid, 1'b1);
        chk("sb_rdata", rsp_rdata, 32'd0);
        chk("sb_addr_done", mem_addr, 32'h103);

        send(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0, a);
        @(negedge clk);
        chk("lh_mis_valid", rsp_valid, 1'b1);
        chk("lh_mis_err", rsp_err, 1'b1);
        chk("lh_mis_nostrobe", mem_memread, 1'b0);
        send(1'b1, 3'b010, 32'h102, 32'h77, 32'h0, 0, 1, 1'b0, a);
        @(negedge clk);
        chk("sw_mis_valid", rsp_valid, 1'b1);
        chk("sw_mis_err", rsp_err, 1'b1);
        chk("sw_mis_nostrobe", mem_memwrite, 1'b0);

        rd_q.delete();
        send(1'b0, 3'b000, 32'h200, 32'h0, 32'hFFFFFF80, 0, 2, 1'b1, a);
        send(1'b0, 3'b000, 32'h201, 32'h0, 32'h0000007F, 0, 2, 1'b0, a2);
        while (edge_n < free_edge + 1) begin @(posedge clk); #1; end
        chk("b2b_pulses", rd_q.size(), 2);
        if (rd_q.size() == 2) chk("b2b_spacing", rd_q[1] - rd_q[0], 6);

        keep = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!keep) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            we = 1'($urandom);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else f3 = we ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            keep = ($urandom_range(0, 2) == 0);
            send(we, f3, addr, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(1, 3), keep, a);
        end
        req_valid = 1'b0;
        while (edge_n < free_edge + 2) begin @(posedge clk); #1; end
        chk_en = 1'b0;

`ifdef LSU_TIMEOUT_EN
        send(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 1, 1'b0, a);
        while (edge_n < a + 8) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("to_not_early", rsp_valid, 1'b0);
        @(negedge clk);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
`endif

        send(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 6, 1'b0, a);
        while (edge_n < a + 3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_memread", mem_memread, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk("rstmid_req_ready", req_ready, 1'b0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        while (edge_n < a + 10) begin
            @(negedge clk);
            chk("rstmid_no_rsp", rsp_valid, 1'b0);
            if (edge_n == a + 6) chk("rstmid_ready_held", req_ready, 1'b0);
            if (edge_n == a + 8) chk("rstmid_ready_back", req_ready, 1'b1);
        end

        summary();
        $finish;
    end
endmodule
`default_nettype wire
